// File: rtl/dmem_pkg.sv
// Shared types and helpers for the DMEM responder: access sizes, write-buffer
// entry layout, byte-enable generation and big-endian lane extraction.
package dmem_pkg;

  localparam int WBUF_IDX_W = 30;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic                  valid;
    logic [WBUF_IDX_W-1:0] index;
    logic [0:3]            be;
    logic [0:31]           data;
  } wbuf_entry_t;

  // offset is the byte offset within the word, already aligned to the size
  function automatic logic [0:3] be_from_size(size_e size, logic [1:0] offset);
    logic [0:3] be;
    case (size)
      SZ_BYTE: be = 4'b1000 >> offset;
      SZ_HALF: be = offset[1] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [0:31] lane_extract(logic [0:31] word, size_e size,
                                               logic [1:0] offset, logic sext);
    logic [0:31] res;
    logic [0:7]  b;
    logic [0:15] h;
    b = word[{offset, 3'b000} +: 8];
    h = word[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: res = {{24{sext & b[0]}}, b};
      SZ_HALF: res = {{16{sext & h[0]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted-store buffer with byte-level forwarding onto the array read.
import dmem_pkg::*;

module dmem_wbuf #(
  parameter int IDX_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             capture,
  input  logic [IDX_W-1:0] cap_index,
  input  logic [0:3]       cap_be,
  input  logic [0:31]      cap_data,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [0:31]      array_word,
  output logic [0:31]      merged,
  output logic             commit_valid,
  output logic [IDX_W-1:0] commit_index,
  output logic [0:3]       commit_be,
  output logic [0:31]      commit_data
);

  wbuf_entry_t entry_q;

  // Only the valid bit needs reset; payload is qualified by it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      entry_q.valid <= 1'b0;
    end else begin
      entry_q.valid <= capture;
      if (capture) begin
        entry_q.index <= WBUF_IDX_W'(cap_index);
        entry_q.be    <= cap_be;
        entry_q.data  <= cap_data;
      end
    end
  end

  always_comb begin
    merged = array_word;
    if (entry_q.valid && entry_q.index == WBUF_IDX_W'(rd_index)) begin
      for (int b = 0; b < 4; b++) begin
        if (entry_q.be[b]) merged[b*8 +: 8] = entry_q.data[b*8 +: 8];
      end
    end
  end

  assign commit_valid = entry_q.valid;
  assign commit_index = entry_q.index[IDX_W-1:0];
  assign commit_be    = entry_q.be;
  assign commit_data  = entry_q.data;

endmodule

// File: rtl/dmem_responder.sv
// Zero-latency-read data memory with a posted one-entry write buffer.
// Optional misaligned-access detection is built when DMEM_MISALIGN_CHECK_EN is defined.
import dmem_pkg::*;

module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] addr_to_mem,
  input  logic        write_enable_to_mem,
  input  logic        byte_to_mem,
  input  logic        half_word_to_mem,
  input  logic        sign_extend_to_mem,
  input  logic [0:31] data_to_mem,
  output logic [0:31] data_from_mem,
  output logic        wbuf_pending,
  output logic        misalign_err,
  output logic [0:7]  misalign_cnt
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [0:31]      mem [DEPTH_WORDS];
  logic [31:0]      rel;
  logic             unused_addr_bits;
  logic [IDX_W-1:0] index;
  size_e            size;
  logic [1:0]       offset;
  logic             misaligned;
  logic [0:3]       be;
  logic [0:31]      store_lanes;
  logic [0:31]      merged;
  logic             commit_valid;
  logic [IDX_W-1:0] commit_index;
  logic [0:3]       commit_be;
  logic [0:31]      commit_data;

  // Addresses outside the array wrap, so the high relative bits are dropped.
  assign rel              = addr_to_mem - ADDR_BASE;
  assign index            = rel[IDX_W+1:2];
  assign unused_addr_bits = ^rel[31:IDX_W+2];

  always_comb begin
    if (byte_to_mem)           size = SZ_BYTE;
    else if (half_word_to_mem) size = SZ_HALF;
    else                       size = SZ_WORD;
  end

  always_comb begin
    case (size)
      SZ_BYTE: offset = rel[1:0];
      SZ_HALF: offset = {rel[1], 1'b0};
      default: offset = 2'b00;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = (size == SZ_HALF && rel[0]) ||
                      (size == SZ_WORD && rel[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    case (size)
      SZ_BYTE: store_lanes = {4{data_to_mem[24:31]}};
      SZ_HALF: store_lanes = {2{data_to_mem[16:31]}};
      default: store_lanes = data_to_mem;
    endcase
  end

  assign be = be_from_size(size, offset);

  dmem_wbuf #(.IDX_W(IDX_W)) u_wbuf (
    .clock        (clock),
    .reset        (reset),
    .capture      (write_enable_to_mem && !misaligned),
    .cap_index    (index),
    .cap_be       (be),
    .cap_data     (store_lanes),
    .rd_index     (index),
    .array_word   (mem[index]),
    .merged       (merged),
    .commit_valid (commit_valid),
    .commit_index (commit_index),
    .commit_be    (commit_be),
    .commit_data  (commit_data)
  );

  // A store still buffered when reset arrives is dropped rather than committed.
  always_ff @(posedge clock) begin
    if (reset && commit_valid) begin
      for (int b = 0; b < 4; b++) begin
        if (commit_be[b]) mem[commit_index][b*8 +: 8] <= commit_data[b*8 +: 8];
      end
    end
  end

  assign data_from_mem = (!reset || misaligned) ? 32'h0
                       : lane_extract(merged, size, offset, sign_extend_to_mem);
  assign wbuf_pending  = commit_valid;

`ifdef DMEM_MISALIGN_CHECK_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      misalign_err <= 1'b0;
      misalign_cnt <= 8'h00;
    end else if (misaligned) begin
      misalign_err <= 1'b1;
      if (misalign_cnt != 8'hFF) misalign_cnt <= misalign_cnt + 8'h01;
    end
  end
`else
  assign misalign_err = 1'b0;
  assign misalign_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of load/store vectors plus hand
// sequences for reset-discard, address wrap and the DMEM_MISALIGN_CHECK_EN option.
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        chk_pend;
    logic        exp_pend;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [0:31] addr_to_mem;
  logic        write_enable_to_mem;
  logic        byte_to_mem;
  logic        half_word_to_mem;
  logic        sign_extend_to_mem;
  logic [0:31] data_to_mem;
  logic [0:31] data_from_mem;
  logic        wbuf_pending;
  logic        misalign_err;
  logic [0:7]  misalign_cnt;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
    .clock               (clock),
    .reset               (reset),
    .addr_to_mem         (addr_to_mem),
    .write_enable_to_mem (write_enable_to_mem),
    .byte_to_mem         (byte_to_mem),
    .half_word_to_mem    (half_word_to_mem),
    .sign_extend_to_mem  (sign_extend_to_mem),
    .data_to_mem         (data_to_mem),
    .data_from_mem       (data_from_mem),
    .wbuf_pending        (wbuf_pending),
    .misalign_err        (misalign_err),
    .misalign_cnt        (misalign_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t st(logic [1:0] sz, logic [31:0] addr, logic [31:0] data,
                              logic chk_pend, logic exp_pend);
    vec_t v;
    v = '{we: 1'b1, sz: sz, sext: 1'b0, addr: addr, data: data, chk_data: 1'b0,
          exp_data: 32'h0, chk_pend: chk_pend, exp_pend: exp_pend};
    return v;
  endfunction

  function automatic vec_t ld(logic [1:0] sz, logic sext, logic [31:0] addr,
                              logic [31:0] exp_data, logic chk_pend, logic exp_pend);
    vec_t v;
    v = '{we: 1'b0, sz: sz, sext: sext, addr: addr, data: 32'h0, chk_data: 1'b1,
          exp_data: exp_data, chk_pend: chk_pend, exp_pend: exp_pend};
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clock);
    #1;
    write_enable_to_mem = v.we;
    byte_to_mem         = (v.sz == 2'd0);
    half_word_to_mem    = (v.sz == 2'd1);
    sign_extend_to_mem  = v.sext;
    addr_to_mem         = v.addr;
    data_to_mem         = v.data;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    @(negedge clock);
    if (v.chk_data) check32({tag, " data"}, data_from_mem, v.exp_data);
    if (v.chk_pend) check32({tag, " pending"}, {31'h0, wbuf_pending}, {31'h0, v.exp_pend});
  endtask

  task automatic cycle(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  task automatic check_err(input string tag, input logic exp_err, input logic [7:0] exp_cnt);
    check32({tag, " misalign_err"}, {31'h0, misalign_err}, {31'h0, exp_err});
    check32({tag, " misalign_cnt"}, {24'h0, misalign_cnt}, {24'h0, exp_cnt});
  endtask

  initial begin
    reset               = 1'b0;
    addr_to_mem         = '0;
    write_enable_to_mem = 1'b0;
    byte_to_mem         = 1'b0;
    half_word_to_mem    = 1'b0;
    sign_extend_to_mem  = 1'b0;
    data_to_mem         = '0;

    // sz: 0 byte, 1 half, 2 word
    vecs.push_back(st(2, 32'h10, 32'hDEADBEEF, 1, 0));
    vecs.push_back(ld(2, 0, 32'h10, 32'hDEADBEEF, 1, 1));
    vecs.push_back(ld(2, 0, 32'h10, 32'hDEADBEEF, 1, 0));
    vecs.push_back(ld(2, 0, 32'h10, 32'hDEADBEEF, 1, 0));
    vecs.push_back(st(2, 32'h20, 32'h11223344, 1, 0));
    vecs.push_back(ld(0, 1, 32'h23, 32'h00000044, 1, 1));
    vecs.push_back(ld(0, 1, 32'h20, 32'h00000011, 1, 0));
    vecs.push_back(st(0, 32'h21, 32'h000000F0, 1, 0));
    vecs.push_back(ld(0, 1, 32'h21, 32'hFFFFFFF0, 1, 1));
    vecs.push_back(ld(0, 0, 32'h21, 32'h000000F0, 1, 0));
    vecs.push_back(ld(2, 0, 32'h20, 32'h11F03344, 1, 0));
    vecs.push_back(ld(1, 1, 32'h22, 32'h00003344, 0, 0));
    vecs.push_back(ld(1, 1, 32'h20, 32'h000011F0, 0, 0));
    vecs.push_back(st(2, 32'h30, 32'hAABBCCDD, 1, 0));
    vecs.push_back(st(1, 32'h32, 32'h00008001, 1, 1));
    vecs.push_back(st(0, 32'h33, 32'h0000007F, 1, 1));
    vecs.push_back(ld(2, 0, 32'h30, 32'hAABB807F, 1, 1));
    vecs.push_back(ld(1, 1, 32'h32, 32'hFFFF807F, 1, 0));
    vecs.push_back(ld(1, 0, 32'h30, 32'h0000AABB, 0, 0));
    vecs.push_back(st(2, 32'h00, 32'h0BADC0DE, 1, 0));
    vecs.push_back(ld(2, 0, BASE + DEPTH * 4, 32'h0BADC0DE, 1, 1));
    vecs.push_back(ld(2, 0, BASE + DEPTH * 4, 32'h0BADC0DE, 1, 0));
    vecs.push_back(ld(2, 0, BASE + DEPTH * 8 + 32'h10, 32'hDEADBEEF, 0, 0));

    repeat (2) @(posedge clock);
    @(negedge clock);
    check32("reset data", data_from_mem, 32'h0);
    check32("reset pending", {31'h0, wbuf_pending}, 32'h0);
    check_err("reset", 1'b0, 8'h00);
    @(posedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i], $sformatf("vec%0d", i));
    end

    // A store still in the buffer when reset hits must be dropped.
    cycle(st(2, 32'h40, 32'hCAFEF00D, 0, 0), "rst_a");
    cycle(ld(2, 0, 32'h40, 32'hCAFEF00D, 1, 1), "rst_b");
    cycle(ld(2, 0, 32'h40, 32'hCAFEF00D, 1, 0), "rst_c");
    cycle(st(2, 32'h40, 32'h12345678, 1, 0), "rst_d");
    applyStimulus(ld(2, 0, 32'h40, 32'h0, 0, 0));
    reset = 1'b0;
    checkOutput(ld(2, 0, 32'h40, 32'h0, 0, 0), "rst_in_reset");
    applyStimulus(ld(2, 0, 32'h40, 32'hCAFEF00D, 1, 0));
    reset = 1'b1;
    checkOutput(ld(2, 0, 32'h40, 32'hCAFEF00D, 1, 0), "rst_after");
    check_err("post_reset", 1'b0, 8'h00);

`ifdef DMEM_MISALIGN_CHECK_EN
    cycle(st(2, 32'h41, 32'h55555555, 1, 0), "mis_store");
    cycle(ld(2, 0, 32'h40, 32'hCAFEF00D, 1, 0), "mis_nochange");
    check_err("mis_one", 1'b1, 8'h01);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) cycle(ld(2, 0, 32'h42, 32'h0, 0, 0), $sformatf("mis_ld%0d", i));
      else            cycle(ld(1, 1, 32'h31, 32'h0, 0, 0), $sformatf("mis_ld%0d", i));
    end
    cycle(ld(2, 0, 32'h30, 32'hAABB807F, 1, 0), "mis_aligned");
    check_err("mis_sat", 1'b1, 8'hFF);
`else
    cycle(ld(2, 0, 32'h13, 32'hDEADBEEF, 1, 0), "align_word");
    cycle(ld(1, 0, 32'h33, 32'h0000807F, 1, 0), "align_half");
    cycle(ld(1, 1, 32'h31, 32'hFFFFAABB, 1, 0), "align_half_s");
    cycle(st(2, 32'h41, 32'h55555555, 1, 0), "align_store");
    cycle(ld(2, 0, 32'h40, 32'h55555555, 1, 1), "align_fwd");
    cycle(ld(2, 0, 32'h40, 32'h55555555, 1, 0), "align_arr");
    check_err("no_check", 1'b0, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that sits on the far side of the processor's DMEM port. It serves the processor's byte, half-word and word loads and stores with a combinational read path, as the MEM stage expects data in the same cycle. Stores are posted into a one-entry write buffer and committed to the word array on the following edge. Loads see buffered data by byte-level forwarding. It replaces the zero-latency behavioural memory in system simulation and FPGA builds.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥4.
- ADDR_BASE, 32'h0000_0000: byte address of word 0; DEPTH_WORDS*4-aligned.
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- addr_to_mem  in  [0:31]  byte address from MEM stage.
- write_enable_to_mem  in  1  1 = store, 0 = load.
- byte_to_mem  in  1  byte access.
- half_word_to_mem  in  1  half-word access; byte_to_mem has priority if both are set.
- sign_extend_to_mem  in  1  sign-extend sub-word loads.
- data_to_mem  in  [0:31]  store data, right-justified; byte in [24:31], half in [16:31].
- data_from_mem  out  [0:31]  load data, right-justified, extended.
- wbuf_pending  out  1  write buffer holds an uncommitted store.
- misalign_err  out  1  sticky misaligned-access flag.
- misalign_cnt  out  [0:7]  saturating misaligned-access count.

## Operation
- Bit 0 is the MSB. Big-endian: byte offset 0 occupies bits [0:7] of the word.
- Word index = (addr - ADDR_BASE)[bits above offset] mod DEPTH_WORDS. Out-of-range addresses wrap; no error.
- Byte offset is addr[30:31]. Half offset is addr[30].
- Byte enables, [0:3]:
  - Byte access: one-hot at the byte offset.
  - Half access: 1100 when addr[30]=0, 0011 when addr[30]=1.
  - Word access: 1111.
- Store data is lane-shifted to the selected bytes.
- Write buffer holds {valid, index, be[0:3], data[0:31]}. At each edge:
  1. If valid, merge the buffer data into array[index] under be.
  2. Then: valid ← write_enable_to_mem, and the buffer captures the current store. Otherwise valid ← 0.
- Load path is combinational:
  - Read array[index].
  - If the buffer is valid and its index matches, buffered bytes replace the array bytes under be.
  - Select the lane, then zero- or sign-extend.
- During a store cycle, data_from_mem shows the pre-store load view of that address. The processor ignores it.
- Back-to-back stores to the same word: the older store commits and the newer store is captured on the same edge. A following load sees both, newest byte wins.
- wbuf_pending equals the buffer valid bit.

## Timing
- Load latency: 0 cycles (combinational from address and control inputs).
- A store presented in cycle N is visible to loads from cycle N+1 through forwarding. It lands in the array at edge N+1 (end of cycle N+1) unless reset intervenes.
- Reset (reset=0 at an edge):
  - Buffer valid ← 0. A pending store is discarded, not committed.
  - misalign_err ← 0, misalign_cnt ← 0.
  - Array contents are untouched.
- While reset=0, data_from_mem is forced to 0.
- misalign_cnt saturates at 8'hFF. misalign_err stays 1 until reset.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - Misaligned accesses are detected: half with addr[31]=1, or word with addr[30:31]≠0.
  - A misaligned store is not captured.
  - A misaligned load returns 0.
  - Each misaligned access sets misalign_err and increments misalign_cnt on the edge.
- Not defined:
  - Low address bits below the access size are ignored (forced aligned).
  - misalign_err and misalign_cnt are tied to 0, and their registers are not built.

## Structure
- Shared package dmem_pkg holds:
  - The access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - The write-buffer entry struct.
  - The function be_from_size(size, offset).
  - The function lane_extract(word, size, offset, sext).
- One sub-module, dmem_wbuf: the write-buffer register plus the forwarding merge, instantiated once. The array, decode and error logic live in the top.

## Test plan
- Store word 32'hDEADBEEF at 0x10, then load word at 0x10 in the next cycle → 32'hDEADBEEF via forwarding. wbuf_pending=1. Load again two cycles later → same value from the array, wbuf_pending=0.
- Word 0x20 = 32'h11223344. Load byte at offset 0x23 with sign extension → 32'h00000044. Offset 0x20 → 32'h00000011. Store byte 8'hF0 at 0x21, then load signed byte at 0x21 → 32'hFFFFFFF0.
- Store half 16'h8001 at 0x32, then store byte 8'h7F at 0x33 back-to-back. Load word at 0x30 → lower half 16'h807F, upper half unchanged.
- Store word at 0x40, then assert reset=0 on the next edge. After reset, load 0x40 → old value, wbuf_pending=0, data_from_mem=0 while in reset.
- With DMEM_MISALIGN_CHECK_EN: word store to 0x41 → no array change, misalign_err=1, cnt=1. Issue 300 misaligned loads → every load returns 0, cnt=8'hFF.
- Load word at ADDR_BASE + DEPTH_WORDS*4 → the contents of word 0 (wrap).
